// File: rtl/tdma_domain_arbiter.sv
// Two-domain TDMA arbiter over a shared register bank with a low/high label check.
// Even words belong to L, odd words to H; L-side timing never depends on H activity.
module tdma_domain_arbiter #(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int SLOT_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [AW-1:0] l_req_addr,
  input  logic [DW-1:0] l_req_wdata,
  output logic          l_resp_valid,
  output logic [DW-1:0] l_resp_rdata,
  output logic          l_resp_err,
  input  logic          h_req_valid,
  output logic          h_req_ready,
  input  logic          h_req_we,
  input  logic [AW-1:0] h_req_addr,
  input  logic [DW-1:0] h_req_wdata,
  output logic          h_resp_valid,
  output logic [DW-1:0] h_resp_rdata,
  output logic          h_resp_err,
  output logic          slot_owner
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(SLOT_LEN);

  logic [CW-1:0] slot_cnt;
  logic [DW-1:0] bank [DEPTH];

  logic          l_full, l_we, h_full, h_we;
  logic [AW-1:0] l_addr, h_addr;
  logic [DW-1:0] l_wdata, h_wdata;

  logic slot_start, l_issue, h_issue, l_deny, h_deny;

  assign l_req_ready = ~l_full;
  assign h_req_ready = ~h_full;

  assign slot_start = (slot_cnt == '0);
  assign l_issue    = l_full & ~slot_owner & slot_start;
  assign h_issue    = h_full &  slot_owner & slot_start;

  // L may not read H words; H may not write L words.
  assign l_deny = ~l_we & l_addr[0];
  assign h_deny =  h_we & ~h_addr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      slot_owner <= 1'b0;
    end else if (slot_cnt == CW'(SLOT_LEN - 1)) begin
      slot_cnt   <= '0;
      slot_owner <= ~slot_owner;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_full  <= 1'b0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (l_issue) begin
      l_full <= 1'b0;
    end else if (l_req_valid && !l_full) begin
      l_full  <= 1'b1;
      l_we    <= l_req_we;
      l_addr  <= l_req_addr;
      l_wdata <= l_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_full  <= 1'b0;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
    end else if (h_issue) begin
      h_full <= 1'b0;
    end else if (h_req_valid && !h_full) begin
      h_full  <= 1'b1;
      h_we    <= h_req_we;
      h_addr  <= h_req_addr;
      h_wdata <= h_req_wdata;
    end
  end

  // Issues never coincide because the two domains own disjoint slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      if (l_issue && l_we) bank[l_addr] <= l_wdata;
      if (h_issue && h_we && !h_deny) bank[h_addr] <= h_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_resp_valid <= 1'b0;
      l_resp_err   <= 1'b0;
      l_resp_rdata <= '0;
      h_resp_valid <= 1'b0;
      h_resp_err   <= 1'b0;
      h_resp_rdata <= '0;
    end else begin
      l_resp_valid <= l_issue;
      l_resp_err   <= l_issue & l_deny;
      l_resp_rdata <= (l_issue && !l_we && !l_deny) ? bank[l_addr] : '0;
      h_resp_valid <= h_issue;
      h_resp_err   <= h_issue & h_deny;
      h_resp_rdata <= (h_issue && !h_we && !h_deny) ? bank[h_addr] : '0;
    end
  end

endmodule

// File: tb/tb_tdma_domain_arbiter.sv
// Scoreboard bench for tdma_domain_arbiter: expected responses (data, error, cycle)
// are queued when a request is accepted and checked when the DUT answers.
module tb_tdma_domain_arbiter;

  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       l_req_valid = 1'b0, l_req_we = 1'b0, l_req_ready;
  logic [1:0] l_req_addr = '0;
  logic [7:0] l_req_wdata = '0;
  logic       l_resp_valid, l_resp_err;
  logic [7:0] l_resp_rdata;
  logic       h_req_valid = 1'b0, h_req_we = 1'b0, h_req_ready;
  logic [1:0] h_req_addr = '0;
  logic [7:0] h_req_wdata = '0;
  logic       h_resp_valid, h_resp_err;
  logic [7:0] h_resp_rdata;
  logic       slot_owner;

  typedef struct {
    int         cyc;
    logic [7:0] rdata;
    logic       err;
  } resp_t;

  resp_t      l_q[$];
  resp_t      h_q[$];
  logic [7:0] m_bank [4];
  int         cyc;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [10:0] trace_q [2][80];
  bit         rec_done;

  tdma_domain_arbiter #(.DW(8), .AW(2), .SLOT_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
    .l_resp_valid(l_resp_valid), .l_resp_rdata(l_resp_rdata), .l_resp_err(l_resp_err),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
    .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata),
    .h_resp_valid(h_resp_valid), .h_resp_rdata(h_resp_rdata), .h_resp_err(h_resp_err),
    .slot_owner(slot_owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Answers are checked on the falling edge, away from the active edge.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n) begin
      if (l_resp_valid) begin
        if (l_q.size() == 0) checkOutput("l_unexpected_resp", 1, 0);
        else begin
          e = l_q.pop_front();
          checkOutput("l_resp_cycle", cyc, e.cyc);
          checkOutput("l_resp_rdata", {24'd0, l_resp_rdata}, {24'd0, e.rdata});
          checkOutput("l_resp_err", {31'd0, l_resp_err}, {31'd0, e.err});
        end
      end
      if (h_resp_valid) begin
        if (h_q.size() == 0) checkOutput("h_unexpected_resp", 1, 0);
        else begin
          e = h_q.pop_front();
          checkOutput("h_resp_cycle", cyc, e.cyc);
          checkOutput("h_resp_rdata", {24'd0, h_resp_rdata}, {24'd0, e.rdata});
          checkOutput("h_resp_err", {31'd0, h_resp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    l_req_valid = 1'b0;
    h_req_valid = 1'b0;
    l_q.delete();
    h_q.delete();
    for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Offers one request, waits for acceptance and queues the expected answer.
  task automatic applyStimulus(input bit dom, input bit we, input logic [1:0] addr,
                               input logic [7:0] wdata);
    bit    acc = 1'b0;
    int    cap = 0;
    int    k;
    resp_t e;
    @(posedge clk); #1;
    if (dom) begin
      h_req_valid = 1'b1; h_req_we = we; h_req_addr = addr; h_req_wdata = wdata;
    end else begin
      l_req_valid = 1'b1; l_req_we = we; l_req_addr = addr; l_req_wdata = wdata;
    end
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = dom ? h_req_ready : l_req_ready;
      cap = cyc;
      @(posedge clk); #1;
    end
    if (dom) h_req_valid = 1'b0;
    else     l_req_valid = 1'b0;
    if (!acc) begin
      checkOutput(dom ? "h_accept_timeout" : "l_accept_timeout", 0, 1);
    end else begin
      k = cap + 1;
      while ((k % (2 * SL)) != (dom ? SL : 0)) k++;
      e.cyc = k + 1;
      e.err = dom ? (we & ~addr[0]) : (~we & addr[0]);
      e.rdata = (we || e.err) ? 8'h00 : m_bank[addr];
      if (we && !e.err) m_bank[addr] = wdata;
      if (dom) h_q.push_back(e);
      else     l_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (l_q.size() != 0 || h_q.size() != 0); i++) @(negedge clk);
    #1;
    checkOutput("drain_pending", l_q.size() + h_q.size(), 0);
    l_q.delete();
    h_q.delete();
  endtask

  task automatic runStream(input int run, input bit with_h);
    doReset();
    rec_done = 1'b0;
    fork
      begin
        applyStimulus(0, 1'b1, 2'd0, 8'h5A);
        applyStimulus(0, 1'b0, 2'd0, 8'h00);
        applyStimulus(0, 1'b0, 2'd1, 8'h00);
        applyStimulus(0, 1'b1, 2'd2, 8'hC3);
        applyStimulus(0, 1'b0, 2'd2, 8'h00);
      end
      begin
        for (int j = 0; with_h && !rec_done && j < 40; j++)
          applyStimulus(1, j[0], j[0] ? 2'd0 : 2'(1 + 2 * (j % 2 + j / 2 % 2)), 8'hEE);
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(negedge clk);
          trace_q[run][i] = {l_req_ready, l_resp_valid, l_resp_err, l_resp_rdata};
        end
        rec_done = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int diffs;

    // Reset state and slot schedule
    doReset();
    for (int i = 0; i < 8; i++) begin
      checkOutput("slot_owner", {31'd0, slot_owner}, (i >= 4) ? 32'd1 : 32'd0);
      if (i == 0) begin
        checkOutput("rst_l_ready", {31'd0, l_req_ready}, 1);
        checkOutput("rst_h_ready", {31'd0, h_req_ready}, 1);
        checkOutput("rst_l_valid", {31'd0, l_resp_valid}, 0);
        checkOutput("rst_h_valid", {31'd0, h_resp_valid}, 0);
      end
      @(negedge clk); #1;
    end
    for (int a = 0; a < 4; a++) begin
      applyStimulus(0, 1'b0, 2'(a), 8'h00);
      applyStimulus(1, 1'b0, 2'(a), 8'h00);
      drain();
    end

    // First write lands in the next L slot; read-back and label checks
    doReset();
    applyStimulus(0, 1'b1, 2'd0, 8'hA5);
    drain();
    applyStimulus(0, 1'b0, 2'd0, 8'h00);
    drain();
    applyStimulus(0, 1'b0, 2'd1, 8'h00);
    drain();
    applyStimulus(1, 1'b1, 2'd0, 8'hFF);
    drain();
    applyStimulus(0, 1'b0, 2'd0, 8'h00);
    drain();
    applyStimulus(0, 1'b1, 2'd1, 8'h3C);
    drain();
    applyStimulus(1, 1'b0, 2'd1, 8'h00);
    applyStimulus(1, 1'b0, 2'd0, 8'h00);
    drain();
    applyStimulus(1, 1'b1, 2'd3, 8'h77);
    drain();
    applyStimulus(1, 1'b0, 2'd3, 8'h00);
    drain();

    // L-side outputs must be identical with H idle and with H busy
    runStream(0, 1'b0);
    runStream(1, 1'b1);
    diffs = 0;
    for (int i = 0; i < 80; i++) if (trace_q[0][i] !== trace_q[1][i]) diffs++;
    checkOutput("noninterference_diffs", diffs, 0);

    // Reset while an L request is buffered discards it
    doReset();
    applyStimulus(0, 1'b1, 2'd2, 8'h77);
    for (int i = 0; i < 20 && cyc < 5; i++) begin @(posedge clk); #1; end
    checkOutput("rst_pulse_cycle", cyc, 5);
    doReset();
    diffs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (l_resp_valid) diffs++;
    end
    checkOutput("rst_discard_resp", diffs, 0);
    checkOutput("rst_after_l_ready", {31'd0, l_req_ready}, 1);
    applyStimulus(0, 1'b0, 2'd2, 8'h00);
    applyStimulus(1, 1'b0, 2'd2, 8'h00);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
